// File: rtl/monitor_pkg.sv
// monitor_pkg: shared definitions for the monitoring-path UART transmitter.
//   state_e   - transmitter FSM states (ST_PARITY only when MONITOR_TX_PARITY_EN
//               is defined)
//   START_BIT, STOP_BIT, DATA_BITS - serial frame constants
package monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef MONITOR_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

endpackage

// File: rtl/monitor_uart_tx_fifo.sv
// monitor_fifo: synchronous FIFO holding samples waiting for transmission.
//   WIDTH, DEPTH (power of two, >= 2)
//   clk, rst_n    - clock, asynchronous active-low reset (discards contents)
//   push, din     - write din when push (caller must not push while full)
//   pop           - drop head (caller must not pop while empty)
//   dout          - head entry, valid when !empty
//   full, empty   - occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module monitor_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = r_mem[r_rd_ptr[AW-1:0]];
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/monitor_uart_tx.sv
// monitor_uart_tx: buffers 8-bit monitoring samples and sends each one as an
// LSB-first asynchronous frame (start, d0..d7, [even parity], stop).
//   CLKS_PER_BIT (2..65535), FIFO_DEPTH (power of two, >= 2)
//   clk, rst_n                - clock, asynchronous active-low reset
//   sample_in, sample_valid   - sample offered to the FIFO
//   sample_ready              - FIFO not full
//   tx                        - registered serial line, idle high
//   busy                      - a frame is in progress
//   overflow                  - sticky: a sample was offered while not ready
// Build option: define MONITOR_TX_PARITY_EN to insert an even parity bit.
//
// state     | meaning
// ST_IDLE   | line idle, waiting for a buffered sample
// ST_START  | sending start bit
// ST_DATA   | sending d0..d7, r_bit_cnt selects the bit
// ST_PARITY | sending even parity (parity builds only)
// ST_STOP   | sending stop bit; chains straight into the next frame if queued
module monitor_uart_tx
  import monitor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam logic [15:0] TIMER_LOAD = 16'(CLKS_PER_BIT - 1);

  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_timer_done;
  logic [7:0] w_head;

  state_e      r_state;
  logic [15:0] r_timer;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_overflow;
`ifdef MONITOR_TX_PARITY_EN
  logic        r_parity;
`endif

  monitor_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (sample_in),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_push       = sample_valid && !w_full;
  assign w_timer_done = (r_timer == 16'd0);
  // Pop when idle, or at the last cycle of a stop bit so frames abut.
  assign w_pop = !w_empty &&
                 ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_timer_done));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= STOP_BIT;
      r_overflow <= 1'b0;
`ifdef MONITOR_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      if (sample_valid && w_full) r_overflow <= 1'b1;

      if (w_pop) begin
        r_shift <= w_head;
`ifdef MONITOR_TX_PARITY_EN
        r_parity <= ^w_head;
`endif
        r_tx    <= START_BIT;
        r_state <= ST_START;
        r_timer <= TIMER_LOAD;
      end else if (r_state != ST_IDLE) begin
        if (!w_timer_done) begin
          r_timer <= r_timer - 1'b1;
        end else begin
          r_timer <= TIMER_LOAD;
          unique case (r_state)
            ST_START: begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
              r_tx      <= r_shift[0];
            end
            ST_DATA: begin
              if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef MONITOR_TX_PARITY_EN
                r_state <= ST_PARITY;
                r_tx    <= r_parity;
`else
                r_state <= ST_STOP;
                r_tx    <= STOP_BIT;
`endif
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_shift   <= r_shift >> 1;
                r_tx      <= r_shift[1];
              end
            end
`ifdef MONITOR_TX_PARITY_EN
            ST_PARITY: begin
              r_state <= ST_STOP;
              r_tx    <= STOP_BIT;
            end
`endif
            ST_STOP: begin
              // Nothing queued (the pop branch above would have won).
              r_state <= ST_IDLE;
              r_timer <= '0;
              r_tx    <= STOP_BIT;
            end
            default: begin
              r_state <= ST_IDLE;
              r_timer <= '0;
              r_tx    <= STOP_BIT;
            end
          endcase
        end
      end
    end
  end

  assign sample_ready = !w_full;
  assign tx           = r_tx;
  assign busy         = (r_state != ST_IDLE);
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_monitor_uart_tx.sv
// Bench for monitor_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A queue-based model predicts the line every cycle; directed sequences add
// hand-written frame literals and cycle counts.
module tb_monitor_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef MONITOR_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] sample_in = 8'h00;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic       tx;
  logic       busy;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;

  monitor_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .tx          (tx),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: q holds accepted samples not yet started; line holds the per-cycle
  // line levels still to be driven for the frame in flight.
  logic [7:0] q[$];
  bit         line[$];
  logic [7:0] m_byte;
  bit         m_tx   = 1'b1;
  bit         m_busy = 1'b0;
  bit         m_ovf  = 1'b0;
  bit         m_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      line.delete();
      m_tx   = 1'b1;
      m_busy = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      m_rdy = (q.size() < DEPTH);
      if (line.size() == 0 && q.size() > 0) begin
        m_byte = q.pop_front();
        for (int i = 0; i < NBITS; i++) begin
          bit v;
          if (i == 0)                       v = 1'b0;
          else if (i <= 8)                  v = m_byte[i-1];
          else if (i == 9 && NBITS == 11)   v = ^m_byte;
          else                              v = 1'b1;
          repeat (CPB) line.push_back(v);
        end
      end
      if (line.size() > 0) begin
        m_tx   = line.pop_front();
        m_busy = 1'b1;
      end else begin
        m_tx   = 1'b1;
        m_busy = 1'b0;
      end
      if (sample_valid) begin
        if (m_rdy) q.push_back(sample_in);
        else       m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_tx", tx, m_tx);
    chk("model_busy", busy, m_busy);
    chk("model_ready", sample_ready, q.size() < DEPTH);
    chk("model_overflow", overflow, m_ovf);
  end

  int bc;
  task automatic step();
    @(negedge clk);
    if (busy) bc++;
  endtask

  task automatic push_one(input logic [7:0] b);
    @(negedge clk);
    sample_in    = b;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // After push_one returns (just past acceptance edge N), cycle k follows edge N+k.
  task automatic check_frame(input string name, input logic [10:0] lit);
    for (int k = 1; k <= NBITS * CPB; k++) begin
      @(negedge clk);
      chk(name, tx, lit[(k-1)/CPB]);
    end
    @(negedge clk);
    chk({name, "_end_busy"}, busy, 1'b0);
    chk({name, "_end_tx"}, tx, 1'b1);
  endtask

  logic [10:0] lit_a5;
  logic [10:0] lit_07;

  initial begin
`ifdef MONITOR_TX_PARITY_EN
    lit_a5 = 11'b1_0_10100101_0;
    lit_07 = 11'b1_1_00000111_0;
`else
    lit_a5 = 11'b0_1_10100101_0;
    lit_07 = 11'b0_1_00000111_0;
`endif
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // idle line
    repeat (100) begin
      @(negedge clk);
      chk("idle_tx", tx, 1'b1);
      chk("idle_busy", busy, 1'b0);
      chk("idle_ready", sample_ready, 1'b1);
      chk("idle_overflow", overflow, 1'b0);
    end

    // single frames
    push_one(8'hA5);
    check_frame("frame_a5", lit_a5);
    push_one(8'h07);
    check_frame("frame_07", lit_07);

    // back-to-back frames
    bc = 0;
    step();
    sample_in = 8'h00; sample_valid = 1'b1;
    step();
    sample_in = 8'hFF;
    step();
    sample_in = 8'h3C;
    step();
    sample_valid = 1'b0;
    repeat (200) step();
    chk("b2b_busy_cycles", bc, 3 * NBITS * CPB);
    chk("b2b_overflow", overflow, 1'b0);

    // full FIFO: one frame in flight, then six offered samples
    bc = 0;
    step();
    sample_in = 8'h11; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 6; i++) begin
      sample_in    = 8'h20 + 8'(i);
      sample_valid = 1'b1;
      step();
      if (i == 3) chk("full_ready_after_4th", sample_ready, 1'b0);
    end
    sample_valid = 1'b0;
    repeat (400) step();
    chk("full_busy_cycles", bc, 5 * NBITS * CPB);
    chk("full_overflow", overflow, 1'b1);

    // reset during data bit 3 with two samples still buffered
    step();
    sample_in = 8'h5A; sample_valid = 1'b1;
    step();
    sample_in = 8'h11;
    step();
    sample_in = 8'h22;
    step();
    sample_valid = 1'b0;
    repeat (16) step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_tx", tx, 1'b1);
    chk("rst_async_busy", busy, 1'b0);
    chk("rst_async_ready", sample_ready, 1'b1);
    chk("rst_async_overflow", overflow, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      chk("post_rst_tx", tx, 1'b1);
      chk("post_rst_busy", busy, 1'b0);
    end
    chk("post_rst_overflow", overflow, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/monitor_uart_tx.md
# monitor_uart_tx

Serial transmitter for the converter's monitoring path. It accepts 8-bit monitoring samples on a valid/ready handshake and buffers them in a small FIFO. Each sample is sent LSB-first as an asynchronous serial frame on a single output pin, so an off-chip logger can read the collected voltage data. It sits downstream of the data collection register and is the only consumer of its monitoring byte.

## Interface
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 4: sample buffer entries; power of two, ≥2.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- sample_in  in  8  monitoring sample to transmit.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  FIFO can accept; transfer occurs on a rising edge with valid && ready.
- tx  out  1  serial line; idle high.
- busy  out  1  a frame is in progress (state ≠ IDLE).
- overflow  out  1  sticky; set when sample_valid=1 while sample_ready=0.

## Operation
- Reset values: tx=1, busy=0, overflow=0, sample_ready=1, FIFO empty, state IDLE, bit timer 0.
- Reset is asynchronous, including mid-frame: tx returns to 1 immediately, FIFO contents are discarded, and the partial frame is abandoned.
- sample_ready = !full. Ready does not account for a same-cycle pop, so a full FIFO with a pop in that cycle still refuses the push.
- Frame: start bit (0), data bits d0..d7, optional parity bit, stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles.
- FSM states and transitions:
  - IDLE: when the FIFO is non-empty, pop the head into the shift register and go to START.
  - START → DATA.
  - DATA: 8 bits, bit counter 0..7 → PARITY (if enabled) or STOP.
  - PARITY → STOP.
  - STOP: on STOP expiry, go to START with an immediate pop if the FIFO is non-empty (zero idle gap); otherwise go to IDLE.
- Bit timer counts CLKS_PER_BIT-1 down to 0. The state advances on the cycle the timer reads 0.
- tx is registered and driven from state, shift-register LSB or parity bit. No combinational path from inputs to tx.
- overflow stays set until rst_n is asserted. Refused samples are not stored.
- Simultaneous push and pop on a non-full FIFO are both performed; the count is unchanged.

## Timing
- Sample accepted at edge N into an empty FIFO with the FSM in IDLE: the pop and tx falling edge occur at edge N+1.
- tx stays low for CLKS_PER_BIT cycles.
- Frame length is 10×CLKS_PER_BIT cycles, or 11×CLKS_PER_BIT with parity.
- busy rises at edge N+1 and falls at the edge the FSM returns to IDLE, i.e. frame end.
- sample_ready changes at the edge after the push or pop that changes fullness.
- Back-to-back frames have no gap between the stop bit and the next start bit.

## Configuration
- MONITOR_TX_PARITY_EN defined: an even parity bit (XOR of d0..d7) is inserted between d7 and stop. The PARITY state exists.
- MONITOR_TX_PARITY_EN undefined: no parity bit is sent. The PARITY state and parity logic are compiled out, and the frame is 10 bits.

## Structure
- Shared package monitor_pkg contains:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - START_BIT=0, STOP_BIT=1, DATA_BITS=8.
- Sub-module monitor_fifo: synchronous FIFO with parameters WIDTH, DEPTH. It has push, pop, din, dout (head, valid when !empty), full and empty. Pointers carry one extra wrap bit to distinguish full from empty.
- Top level contains only the FSM, bit timer, shift register, tx register and overflow flag.

## Test plan
- Reset and idle: CLKS_PER_BIT=4, no input → tx=1, busy=0, sample_ready=1, overflow=0 for 100 cycles.
- Single frame: push 0xA5 → tx low at acceptance edge +1; bits 1,0,1,0,0,1,0,1 then stop, 4 cycles each; 40 cycles total (44 with parity, parity bit=0).
- Back-to-back: push 0x00, 0xFF, 0x3C in consecutive cycles → three contiguous frames, no idle cycle between them, busy high throughout. Parity bits 0,0,0 under MONITOR_TX_PARITY_EN.
- Full FIFO: hold valid for 6 cycles with FIFO_DEPTH=4 while a frame is active → sample_ready drops after the 4th push, overflow=1, exactly 5 frames sent (1 popped + 4 buffered).
- Reset mid-frame: assert rst_n low during data bit 3 → tx=1 asynchronously, FIFO empty. After release there are no residual frames and overflow=0.
- Parity variant: 0x07 with MONITOR_TX_PARITY_EN → parity bit=1; without the macro the frame is 10 bits and the stop bit follows d7.
